// File: rtl/scc_mem_pkg.sv
// Shared types for the memory arbiter: FSM state encoding and grant owner codes.
package scc_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_IF   = 2'b01;
    localparam logic [1:0] GNT_D    = 2'b10;

endpackage

// File: rtl/arb_timeout_ctr.sv
// Down-counter bounding the ACTIVE phase; o_expire marks the last allowed ACTIVE cycle.
// Instantiated by mem_arbiter only when MEM_ARB_TIMEOUT_EN is defined.
module arb_timeout_ctr #(
    parameter int CYCLES = 16
) (
    input  logic clk,
    input  logic reset_s,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire
);
    localparam int              CW       = $clog2(CYCLES + 1);
    localparam logic [CW-1:0]   LOAD_VAL = CW'(CYCLES - 1);

    logic [CW-1:0] r_cnt;

    // Loaded on grant so that the count reaches zero in the CYCLES-th ACTIVE cycle.
    always_ff @(posedge clk) begin
        if (!reset_s) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expire = i_en && (r_cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between a fetch and a data requester.
// Optional ACTIVE-phase timeout enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
    import scc_mem_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset_s,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        grant,
    output logic              busy
);
    state_t            r_state;
    logic              r_last_d;
    logic              w_any;
    logic              w_pick_d;
    logic              w_timeout;
    logic [DATA_W-1:0] w_rdata_cap;

    assign w_any    = if_req || d_req;
    // Data wins only when alone or when fetch was served last.
    assign w_pick_d = d_req && (!if_req || !r_last_d);
    assign w_rdata_cap = (mem_ack && !mem_we) ? mem_rdata : '0;

`ifdef MEM_ARB_TIMEOUT_EN
    arb_timeout_ctr #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk      (clk),
        .reset_s  (reset_s),
        .i_load   ((r_state == ST_IDLE) && w_any),
        .i_en     (r_state == ST_ACTIVE),
        .o_expire (w_timeout)
    );
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
    assign w_timeout    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_s) begin
            r_state   <= ST_IDLE;
            r_last_d  <= 1'b1;
            grant     <= GNT_NONE;
            busy      <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ack    <= 1'b0;
            if_rdata  <= '0;
            if_err    <= 1'b0;
            d_ack     <= 1'b0;
            d_rdata   <= '0;
            d_err     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state   <= ST_ACTIVE;
                        r_last_d  <= w_pick_d;
                        grant     <= w_pick_d ? GNT_D : GNT_IF;
                        busy      <= 1'b1;
                        mem_req   <= 1'b1;
                        mem_we    <= w_pick_d && d_we;
                        mem_addr  <= w_pick_d ? d_addr : if_addr;
                        mem_wdata <= w_pick_d ? d_wdata : '0;
                    end
                end
                ST_ACTIVE: begin
                    // A real completion in the expiry cycle takes priority over the timeout.
                    if (mem_ack || w_timeout) begin
                        r_state   <= ST_DONE;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        if (grant == GNT_D) begin
                            d_ack   <= 1'b1;
                            d_rdata <= w_rdata_cap;
                            d_err   <= !mem_ack;
                        end else begin
                            if_ack   <= 1'b1;
                            if_rdata <= w_rdata_cap;
                            if_err   <= !mem_ack;
                        end
                    end
                end
                ST_DONE: begin
                    r_state  <= ST_IDLE;
                    grant    <= GNT_NONE;
                    busy     <= 1'b0;
                    if_ack   <= 1'b0;
                    if_rdata <= '0;
                    if_err   <= 1'b0;
                    d_ack    <= 1'b0;
                    d_rdata  <= '0;
                    d_err    <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table plus directed reset/timeout sequences.
module tb_mem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          reset_s;
    logic          if_req, d_req, d_we, mem_ack;
    logic [AW-1:0] if_addr, d_addr;
    logic [DW-1:0] d_wdata, mem_rdata;
    logic          if_ack, if_err, d_ack, d_err, mem_req, mem_we, busy;
    logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [1:0]    grant;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset_s(reset_s),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;

    typedef struct {
        logic [1:0]  gnt;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        logic        rst;
        logic        ifr;
        logic        dr;
        logic        we;
        logic [31:0] ia;
        logic [31:0] da;
        logic [31:0] wd;
        logic [31:0] rd_if;
        logic [31:0] rd_d;
        int          dly_if;
        int          dly_d;
    } vec_t;

    exp_t sb[$];
    logic model_last_d;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input logic is_d, input logic we, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] rd, input logic err);
        exp_t e;
        e.gnt   = is_d ? 2'b10 : 2'b01;
        e.we    = is_d && we;
        e.addr  = a;
        e.wdata = wd;
        e.rdata = (e.we || err) ? 32'h0 : rd;
        e.err   = err;
        return e;
    endfunction

    task automatic do_reset;
        reset_s = 1'b0;
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        tick;
        tick;
        chk1 ("rst_busy", busy, 1'b0);
        chk32("rst_grant", 32'(grant), 32'h0);
        chk1 ("rst_mem_req", mem_req, 1'b0);
        chk1 ("rst_mem_we", mem_we, 1'b0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        chk1 ("rst_acks", if_ack | d_ack, 1'b0);
        chk1 ("rst_errs", if_err | d_err, 1'b0);
        chk32("rst_rdata", if_rdata | d_rdata, 32'h0);
        reset_s = 1'b1;
        model_last_d = 1'b1;
    endtask

    // Entered in the first ACTIVE cycle; returns in the IDLE cycle after the ack.
    task automatic serve(input int dly, input logic [31:0] mrd);
        exp_t e;
        logic is_d;
        chk1("sb_has_entry", sb.size() != 0, 1'b1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        is_d = (e.gnt == 2'b10);
        chk1 ("act_busy", busy, 1'b1);
        chk1 ("act_mem_req", mem_req, 1'b1);
        chk32("act_grant", 32'(grant), 32'(e.gnt));
        chk1 ("act_mem_we", mem_we, e.we);
        chk32("act_mem_addr", mem_addr, e.addr);
        if (e.we) chk32("act_mem_wdata", mem_wdata, e.wdata);
        for (int c = 0; c < dly; c++) begin
            if (is_d && !if_req) if_addr = $urandom;
            if (!is_d && !d_req) d_addr = $urandom;
            tick;
            chk1 ("wait_mem_req", mem_req, 1'b1);
            chk32("wait_mem_addr", mem_addr, e.addr);
            chk1 ("wait_no_ack", if_ack | d_ack, 1'b0);
            chk1 ("wait_no_err", if_err | d_err, 1'b0);
        end
        mem_ack = 1'b1;
        mem_rdata = mrd;
        tick;
        mem_ack = 1'b0;
        mem_rdata = $urandom;
        chk1 ("done_mem_req", mem_req, 1'b0);
        chk32("done_grant", 32'(grant), 32'(e.gnt));
        chk1 ("done_busy", busy, 1'b1);
        if (is_d) begin
            chk1 ("done_d_ack", d_ack, 1'b1);
            chk32("done_d_rdata", d_rdata, e.rdata);
            chk1 ("done_d_err", d_err, e.err);
            chk1 ("done_if_quiet", if_ack | if_err | (|if_rdata), 1'b0);
            d_req = 1'b0;
        end else begin
            chk1 ("done_if_ack", if_ack, 1'b1);
            chk32("done_if_rdata", if_rdata, e.rdata);
            chk1 ("done_if_err", if_err, e.err);
            chk1 ("done_d_quiet", d_ack | d_err | (|d_rdata), 1'b0);
            if_req = 1'b0;
        end
        tick;
        chk1 ("idle_busy", busy, 1'b0);
        chk32("idle_grant", 32'(grant), 32'h0);
        chk1 ("idle_acks", if_ack | d_ack, 1'b0);
    endtask

    vec_t vecs[7];

    initial begin
        vec_t v;
        logic first_d, both;
        exp_t e_if, e_d;

        vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h10,  32'h0,   32'h0,        32'hDEADBEEF, 32'h0,        0, 0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h200, 32'h0,        32'h11111111, 32'h22222222, 1, 0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h104, 32'h204, 32'h0,        32'h33333333, 32'h44444444, 0, 2};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h108, 32'h0,   32'h0,        32'h55555555, 32'h0,        1, 0};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h10C, 32'h208, 32'h0,        32'h66666666, 32'h77777777, 0, 1};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0,   32'h20,  32'h5A5A5A5A, 32'h0,        32'hFFFFFFFF, 0, 2};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h110, 32'h30,  32'hA5A5A5A5, 32'h12345678, 32'hCAFEF00D, 1, 1};

        reset_s = 1'b0;
        model_last_d = 1'b1;

        for (int i = 0; i < 7; i++) begin
            v = vecs[i];
            if (v.rst) do_reset;
            if_req = v.ifr; if_addr = v.ia;
            d_req = v.dr; d_we = v.we; d_addr = v.da; d_wdata = v.wd;
            first_d = v.dr && (!v.ifr || !model_last_d);
            both = v.ifr && v.dr;
            e_if = mk(1'b0, 1'b0, v.ia, 32'h0, v.rd_if, 1'b0);
            e_d  = mk(1'b1, v.we, v.da, v.wd, v.rd_d, 1'b0);
            if (first_d) sb.push_back(e_d); else sb.push_back(e_if);
            if (both) begin
                if (first_d) sb.push_back(e_if); else sb.push_back(e_d);
                model_last_d = !first_d;
            end else begin
                model_last_d = first_d;
            end
            tick;
            if (first_d) serve(v.dly_d, v.rd_d); else serve(v.dly_if, v.rd_if);
            if (both) begin
                tick;
                if (first_d) serve(v.dly_if, v.rd_if); else serve(v.dly_d, v.rd_d);
            end
        end

        // mem_ack with nobody requesting must not start anything
        mem_ack = 1'b1;
        mem_rdata = 32'hBAD0BAD0;
        tick;
        mem_ack = 1'b0;
        chk1("idle_ack_busy", busy, 1'b0);
        chk1("idle_ack_noack", if_ack | d_ack, 1'b0);
        chk1("idle_ack_memreq", mem_req, 1'b0);

        // reset in the middle of ACTIVE, then a normal request afterwards
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
        tick;
        chk1("pre_rst_mem_req", mem_req, 1'b1);
        reset_s = 1'b0;
        tick;
        chk1 ("mid_rst_mem_req", mem_req, 1'b0);
        chk1 ("mid_rst_busy", busy, 1'b0);
        chk32("mid_rst_grant", 32'(grant), 32'h0);
        chk1 ("mid_rst_no_ack", d_ack | if_ack, 1'b0);
        reset_s = 1'b1;
        model_last_d = 1'b1;
        d_addr = 32'h48;
        sb.push_back(mk(1'b1, 1'b0, 32'h48, 32'h0, 32'h99, 1'b0));
        tick;
        serve(0, 32'h99);

`ifdef MEM_ARB_TIMEOUT_EN
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h60;
        tick;
        for (int c = 1; c < TMO; c++) begin
            chk1("tmo_mem_req", mem_req, 1'b1);
            chk1("tmo_no_ack", d_ack, 1'b0);
            tick;
        end
        chk1("tmo_last_mem_req", mem_req, 1'b1);
        tick;
        chk1 ("tmo_d_ack", d_ack, 1'b1);
        chk1 ("tmo_d_err", d_err, 1'b1);
        chk32("tmo_d_rdata", d_rdata, 32'h0);
        chk1 ("tmo_mem_req_low", mem_req, 1'b0);
        d_req = 1'b0;
        tick;
        chk1("tmo_idle_busy", busy, 1'b0);

        d_req = 1'b1; d_addr = 32'h64;
        sb.push_back(mk(1'b1, 1'b0, 32'h64, 32'h0, 32'h77, 1'b0));
        tick;
        serve(TMO - 1, 32'h77);
`else
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h68;
        sb.push_back(mk(1'b1, 1'b0, 32'h68, 32'h0, 32'h88, 1'b0));
        tick;
        serve(TMO + 4, 32'h88);
`endif

        chk32("sb_drained", sb.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be, one per line, name, default, meaning:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT_CYCLES, 16, maximum number of ACTIVE cycles without mem_ack.
REQ-002 Ports SHALL be, one per line, name, direction, width, meaning:
- clk  in  1  sole clock; all state changes on its rising edge.
- reset_s  in  1  synchronous, active-low reset.
- if_req  in  1  fetch request level.
- if_addr  in  ADDR_W  fetch address.
- if_ack  out  1  fetch completion pulse.
- if_rdata  out  DATA_W  fetched word.
- if_err  out  1  fetch timed out.
- d_req  in  1  data request level.
- d_we  in  1  data write (1) or read (0).
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_ack  out  1  data completion pulse.
- d_rdata  out  DATA_W  read data.
- d_err  out  1  data timed out.
- mem_req  out  1  shared-port request.
- mem_we  out  1  shared-port write.
- mem_addr  out  ADDR_W  shared-port address.
- mem_wdata  out  DATA_W  shared-port write data.
- mem_ack  in  1  shared-port completion.
- mem_rdata  in  DATA_W  shared-port read data.
- grant  out  2  owner: 00 none, 01 fetch, 10 data.
- busy  out  1  state is not IDLE.

Function
REQ-003 The FSM SHALL have the states IDLE, ACTIVE and DONE; every output SHALL be registered.
REQ-004 In IDLE, if either req is high, the block SHALL grant one requester, latch that requester's addr/we/wdata, and enter ACTIVE on the next edge.
REQ-005 When both reqs are high, the winner SHALL be the requester not granted last (round-robin).
REQ-006 In ACTIVE, mem_req SHALL be 1 and mem_we/mem_addr/mem_wdata SHALL hold the latched values, unchanged by requester inputs.
REQ-007 An ACTIVE cycle with mem_ack=1 SHALL capture mem_rdata and move the FSM to DONE.
REQ-008 In DONE, for exactly one cycle:
- the granted requester's ack SHALL be 1 and its rdata SHALL be valid;
- rdata SHALL be 0 for writes;
- mem_req SHALL be 0.
The FSM SHALL then return to IDLE.
REQ-009 Minimum latency SHALL be: req sampled in cycle N, mem_req high in cycle N+1, ack in cycle N+2 when mem_ack arrives in cycle N+1.
REQ-010 A requester SHALL hold req and its payload until its ack cycle; a req seen in the cycle after ack SHALL be treated as a new request.
REQ-011 mem_ack SHALL be ignored in IDLE and DONE.
REQ-012 grant SHALL be nonzero in ACTIVE and DONE only; busy SHALL equal (state != IDLE).
REQ-013 Every ack, err and rdata output not belonging to the granted requester SHALL remain 0.

Reset
REQ-014 With reset_s=0 at an edge, the block SHALL:
- enter IDLE;
- drive all outputs to 0;
- clear the timeout counter;
- set last-granted to data, so fetch wins the first tie.
REQ-015 A reset during ACTIVE or DONE SHALL abandon the transaction, with mem_req 0 in the next cycle and no ack issued.

Configuration
REQ-016 With MEM_ARB_TIMEOUT_EN defined, the timeout behaviour SHALL be:
- a counter SHALL count ACTIVE cycles;
- after TIMEOUT_CYCLES cycles without mem_ack, the FSM SHALL enter DONE with ack=1, err=1 and rdata=0;
- if mem_ack arrives in the expiry cycle, the mem_ack completion SHALL win and err SHALL be 0.
REQ-017 With MEM_ARB_TIMEOUT_EN undefined, ACTIVE SHALL wait indefinitely, if_err/d_err SHALL be constant 0, and no counter SHALL exist.

Structure
REQ-018 The shared package scc_mem_pkg SHALL hold the state enum typedef and the grant encodings GNT_NONE, GNT_IF and GNT_D.
REQ-019 The timeout counter SHALL be the single sub-module arb_timeout_ctr, instantiated only under MEM_ARB_TIMEOUT_EN.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Lone fetch: if_req=1, if_addr=0x10, mem_ack in the first ACTIVE cycle with mem_rdata=0xDEADBEEF -> if_ack in cycle N+2 with if_rdata=0xDEADBEEF and grant=01 during ACTIVE.
- Tie: both reqs high after reset -> fetch served first, then data; repeated ties alternate.
- Write: d_we=1, d_addr=0x20, d_wdata=0x5A5A5A5A -> mem_we=1, mem_addr=0x20, mem_wdata=0x5A5A5A5A, then d_ack=1 with d_rdata=0.
- Timeout (macro defined, TIMEOUT_CYCLES=16, no mem_ack) -> d_ack=1 and d_err=1 after 16 ACTIVE cycles; mem_ack in the 16th cycle -> d_err=0.
- Reset mid-ACTIVE: reset_s=0 during ACTIVE -> next cycle mem_req=0, busy=0, grant=00, no ack; a new request after reset is served normally.
